// File: rtl/bypass_reg_bank.sv
// rtl/bypass_reg_bank.sv - host-visible control/status register bank behind a BRAM-style bypass port
//
// Two-stage pipeline that accepts one access per cycle with no backpressure.
// A request sampled in cycle T executes in T+1. Its results (write, read data,
// write pulse, error count) are registered at the end of T+1 and so are visible in T+2.
//
// Index map (word index = bram_addr_a[WORD_LSB +: IDX_W]):
//   0 .. N_CTRL-1                control words, host read/write with byte lanes
//   N_CTRL .. N_CTRL+N_STAT-1    status words, host read-only
//   above                        out of range: writes dropped, reads return 0,
//                                both bump acc_err_cnt
//
// Ports:
//   user_clk, user_aresetn       clock, asynchronous active-low reset
//   bram_en_a                    access strobe
//   bram_we_a                    byte write enables; all zero with bram_en_a means a read
//   bram_addr_a                  byte address
//   bram_wrdata_a                write data
//   bram_rddata_a                read data, held until the next read
//   bram_rdvalid_a               1-cycle strobe marking fresh read data
//   ctrl_reg                     control words, word i at [i*DATA_W +: DATA_W]
//   ctrl_wr_pulse                1-cycle strobe per control word on a write
//   stat_reg                     live status words from fabric
//   acc_err_cnt                  saturating illegal-access count
//
// Configuration macro: BYPASS_STAT_SNAP_EN
//   defined   - the status shadow is frozen. A read of index N_CTRL reloads every
//               shadow word at once and returns the freshly loaded word 0. This
//               gives coherent multi-word status reads.
//   undefined - the status shadow samples stat_reg every cycle.

module bypass_reg_bank #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 16,
    parameter int N_CTRL = 32,
    parameter int N_STAT = 32
) (
    input  logic                       user_clk,
    input  logic                       user_aresetn,
    input  logic                       bram_en_a,
    input  logic [DATA_W/8-1:0]        bram_we_a,
    input  logic [ADDR_W-1:0]          bram_addr_a,
    input  logic [DATA_W-1:0]          bram_wrdata_a,
    output logic [DATA_W-1:0]          bram_rddata_a,
    output logic                       bram_rdvalid_a,
    output logic [N_CTRL*DATA_W-1:0]   ctrl_reg,
    output logic [N_CTRL-1:0]          ctrl_wr_pulse,
    input  logic [N_STAT*DATA_W-1:0]   stat_reg,
    output logic [15:0]                acc_err_cnt
);

    localparam int N_BYTES  = DATA_W / 8;
    localparam int WORD_LSB = $clog2(N_BYTES);
    localparam int IDX_W    = $clog2(N_CTRL + N_STAT);

    // The index is zero-extended by one bit so that the range limits always fit,
    // including when N_CTRL+N_STAT is an exact power of two.
    localparam logic [IDX_W:0] CTRL_END = (IDX_W + 1)'(N_CTRL);
    localparam logic [IDX_W:0] TOT_END  = (IDX_W + 1)'(N_CTRL + N_STAT);

    // Address bits outside the word-index field carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bram_addr_a;

    // Stage 1: the sampled request.
    logic                s1_valid;
    logic [N_BYTES-1:0]  s1_we;
    logic [IDX_W-1:0]    s1_idx;
    logic [DATA_W-1:0]   s1_data;

    always_ff @(posedge user_clk or negedge user_aresetn) begin
        if (!user_aresetn) begin
            s1_valid <= 1'b0;
            s1_we    <= '0;
            s1_idx   <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= bram_en_a;
            if (bram_en_a) begin
                s1_we   <= bram_we_a;
                s1_idx  <= bram_addr_a[WORD_LSB +: IDX_W];
                s1_data <= bram_wrdata_a;
            end
        end
    end

    // Execute-stage decode.
    logic              s1_is_wr;
    logic              s1_is_rd;
    logic [IDX_W:0]    idx_ext;
    logic              in_ctrl;
    logic              in_range;
    logic              err_hit;
    logic              snap_load;
    logic [N_CTRL-1:0] wr_hit;

    assign s1_is_wr = s1_valid && (|s1_we);
    assign s1_is_rd = s1_valid && !(|s1_we);
    assign idx_ext  = {1'b0, s1_idx};
    assign in_ctrl  = idx_ext < CTRL_END;
    assign in_range = idx_ext < TOT_END;
    assign err_hit  = (s1_is_wr && !in_ctrl) || (s1_is_rd && !in_range);

`ifdef BYPASS_STAT_SNAP_EN
    assign snap_load = s1_is_rd && (idx_ext == CTRL_END);
`else
    assign snap_load = 1'b0;
`endif

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < N_CTRL; i++) begin
            wr_hit[i] = s1_is_wr && (s1_idx == IDX_W'(i));
        end
    end

    // Control words and their write pulses.
    logic [DATA_W-1:0] ctrl_q [N_CTRL];

    always_ff @(posedge user_clk or negedge user_aresetn) begin
        if (!user_aresetn) begin
            for (int i = 0; i < N_CTRL; i++) begin
                ctrl_q[i] <= '0;
            end
            ctrl_wr_pulse <= '0;
        end else begin
            ctrl_wr_pulse <= wr_hit;
            for (int i = 0; i < N_CTRL; i++) begin
                for (int b = 0; b < N_BYTES; b++) begin
                    if (wr_hit[i] && s1_we[b]) begin
                        ctrl_q[i][b*8 +: 8] <= s1_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < N_CTRL; g++) begin : g_ctrl_out
        assign ctrl_reg[g*DATA_W +: DATA_W] = ctrl_q[g];
    end

    // Status shadow.
    logic [DATA_W-1:0] stat_sh [N_STAT];

    always_ff @(posedge user_clk or negedge user_aresetn) begin
        if (!user_aresetn) begin
            for (int j = 0; j < N_STAT; j++) begin
                stat_sh[j] <= '0;
            end
        end else begin
`ifdef BYPASS_STAT_SNAP_EN
            if (snap_load) begin
                for (int j = 0; j < N_STAT; j++) begin
                    stat_sh[j] <= stat_reg[j*DATA_W +: DATA_W];
                end
            end
`else
            for (int j = 0; j < N_STAT; j++) begin
                stat_sh[j] <= stat_reg[j*DATA_W +: DATA_W];
            end
`endif
        end
    end

    // Read mux. An index that matches no word leaves rd_word at zero.
    // A snapshot read returns live word 0, which is the value being loaded
    // into the shadow in this cycle.
    logic [DATA_W-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_CTRL; i++) begin
            if (s1_idx == IDX_W'(i)) begin
                rd_word = ctrl_q[i];
            end
        end
        for (int j = 0; j < N_STAT; j++) begin
            if (s1_idx == IDX_W'(N_CTRL + j)) begin
                rd_word = stat_sh[j];
            end
        end
        if (snap_load) begin
            rd_word = stat_reg[DATA_W-1:0];
        end
    end

    // Read return and error counter.
    always_ff @(posedge user_clk or negedge user_aresetn) begin
        if (!user_aresetn) begin
            bram_rddata_a  <= '0;
            bram_rdvalid_a <= 1'b0;
            acc_err_cnt    <= '0;
        end else begin
            bram_rdvalid_a <= s1_is_rd;
            if (s1_is_rd) begin
                bram_rddata_a <= rd_word;
            end
            if (err_hit && (acc_err_cnt != 16'hFFFF)) begin
                acc_err_cnt <= acc_err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bypass_reg_bank.sv
// tb/tb_bypass_reg_bank.sv - directed self-checking bench for bypass_reg_bank
module tb_bypass_reg_bank;

    localparam int DW     = 64;
    localparam int AW     = 16;
    localparam int NC     = 4;
    localparam int NS     = 6;
    localparam int NB     = DW / 8;
    localparam int WLSB   = 3;

    localparam logic [DW-1:0] D0  = 64'h1111_2222_3333_4444;
    localparam logic [DW-1:0] D1  = 64'hA5A5_0F0F_5A5A_F0F0;
    localparam logic [DW-1:0] D2  = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [DW-1:0] D3  = 64'h0123_4567_89AB_CDEF;
    localparam logic [DW-1:0] S0  = 64'h5000_0000_0000_0050;
    localparam logic [DW-1:0] S1  = 64'h0000_0000_0000_1001;
    localparam logic [DW-1:0] S1N = 64'h0000_0000_0000_2002;
    localparam logic [DW-1:0] S5  = 64'h0000_0000_0000_ABCD;

    logic                 user_clk;
    logic                 user_aresetn;
    logic                 bram_en_a;
    logic [NB-1:0]        bram_we_a;
    logic [AW-1:0]        bram_addr_a;
    logic [DW-1:0]        bram_wrdata_a;
    logic [DW-1:0]        bram_rddata_a;
    logic                 bram_rdvalid_a;
    logic [NC*DW-1:0]     ctrl_reg;
    logic [NC-1:0]        ctrl_wr_pulse;
    logic [NS*DW-1:0]     stat_reg;
    logic [15:0]          acc_err_cnt;

    int checks = 0;
    int errors = 0;

    bypass_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .N_CTRL(NC), .N_STAT(NS)) dut (
        .user_clk       (user_clk),
        .user_aresetn   (user_aresetn),
        .bram_en_a      (bram_en_a),
        .bram_we_a      (bram_we_a),
        .bram_addr_a    (bram_addr_a),
        .bram_wrdata_a  (bram_wrdata_a),
        .bram_rddata_a  (bram_rddata_a),
        .bram_rdvalid_a (bram_rdvalid_a),
        .ctrl_reg       (ctrl_reg),
        .ctrl_wr_pulse  (ctrl_wr_pulse),
        .stat_reg       (stat_reg),
        .acc_err_cnt    (acc_err_cnt)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [NB-1:0] we, input int idx, input logic [DW-1:0] data);
        bram_en_a     = en;
        bram_we_a     = we;
        bram_addr_a   = AW'(idx << WLSB);
        bram_wrdata_a = data;
    endtask

    task automatic set_stat(input int j, input logic [DW-1:0] val);
        stat_reg[j*DW +: DW] = val;
    endtask

    task automatic test_reset();
        user_aresetn = 1'b0;
        drive(1'b0, '0, 0, '0);
        repeat (3) tick();
        checks++; if (ctrl_reg !== '0) begin errors++; $display("FAIL reset_ctrl got %h want 0", ctrl_reg); end
        checks++; if (ctrl_wr_pulse !== '0) begin errors++; $display("FAIL reset_pulse got %h want 0", ctrl_wr_pulse); end
        checks++; if (bram_rddata_a !== '0) begin errors++; $display("FAIL reset_rddata got %h want 0", bram_rddata_a); end
        checks++; if (bram_rdvalid_a !== 1'b0) begin errors++; $display("FAIL reset_rdvalid got %b want 0", bram_rdvalid_a); end
        checks++; if (acc_err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err got %h want 0", acc_err_cnt); end
        user_aresetn = 1'b1;
        tick();
        // mid-stream reset: word 0 already written, word 1 in flight
        drive(1'b1, '1, 0, D0);
        tick();
        drive(1'b1, '1, 1, D1);
        tick();
        checks++; if (ctrl_reg[0 +: DW] !== D0) begin errors++; $display("FAIL pre_reset_word0 got %h want %h", ctrl_reg[0 +: DW], D0); end
        #2;
        user_aresetn = 1'b0;
        #1;
        checks++; if (ctrl_reg !== '0) begin errors++; $display("FAIL async_reset_ctrl got %h want 0", ctrl_reg); end
        checks++; if (ctrl_wr_pulse !== '0) begin errors++; $display("FAIL async_reset_pulse got %h want 0", ctrl_wr_pulse); end
        drive(1'b0, '0, 0, '0);
        #1;
        user_aresetn = 1'b1;
        tick();
        checks++; if (ctrl_wr_pulse !== '0) begin errors++; $display("FAIL post_reset_pulse1 got %h want 0", ctrl_wr_pulse); end
        tick();
        checks++; if (ctrl_wr_pulse !== '0) begin errors++; $display("FAIL post_reset_pulse2 got %h want 0", ctrl_wr_pulse); end
        checks++; if (ctrl_reg !== '0) begin errors++; $display("FAIL post_reset_ctrl got %h want 0", ctrl_reg); end
    endtask

    task automatic test_byte_mask();
        drive(1'b1, 8'h0F, 3, '1);
        tick();
        drive(1'b0, '0, 0, '0);
        checks++; if (ctrl_wr_pulse !== 4'b0000) begin errors++; $display("FAIL mask_pulse_early got %b want 0000", ctrl_wr_pulse); end
        tick();
        checks++; if (ctrl_reg[3*DW +: DW] !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL mask_word3 got %h want 00000000ffffffff", ctrl_reg[3*DW +: DW]); end
        checks++; if (ctrl_wr_pulse !== 4'b1000) begin errors++; $display("FAIL mask_pulse got %b want 1000", ctrl_wr_pulse); end
        tick();
        checks++; if (ctrl_wr_pulse !== 4'b0000) begin errors++; $display("FAIL mask_pulse_late got %b want 0000", ctrl_wr_pulse); end
        checks++; if (ctrl_reg[3*DW +: DW] !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL mask_word3_hold got %h want 00000000ffffffff", ctrl_reg[3*DW +: DW]); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, '1, 0, D0);
        tick();
        drive(1'b1, '1, 1, D1);
        tick();
        checks++; if (ctrl_wr_pulse !== 4'b0001) begin errors++; $display("FAIL b2b_pulse0 got %b want 0001", ctrl_wr_pulse); end
        drive(1'b1, '1, 2, D2);
        tick();
        checks++; if (ctrl_wr_pulse !== 4'b0010) begin errors++; $display("FAIL b2b_pulse1 got %b want 0010", ctrl_wr_pulse); end
        drive(1'b1, '0, 1, '0);
        tick();
        drive(1'b0, '0, 0, '0);
        checks++; if (ctrl_wr_pulse !== 4'b0100) begin errors++; $display("FAIL b2b_pulse2 got %b want 0100", ctrl_wr_pulse); end
        checks++; if (bram_rdvalid_a !== 1'b0) begin errors++; $display("FAIL b2b_rdvalid_early got %b want 0", bram_rdvalid_a); end
        tick();
        checks++; if (bram_rdvalid_a !== 1'b1) begin errors++; $display("FAIL b2b_rdvalid got %b want 1", bram_rdvalid_a); end
        checks++; if (bram_rddata_a !== D1) begin errors++; $display("FAIL b2b_rddata got %h want %h", bram_rddata_a, D1); end
        checks++; if (ctrl_wr_pulse !== 4'b0000) begin errors++; $display("FAIL b2b_pulse_idle got %b want 0000", ctrl_wr_pulse); end
        tick();
        checks++; if (bram_rdvalid_a !== 1'b0) begin errors++; $display("FAIL b2b_rdvalid_late got %b want 0", bram_rdvalid_a); end
        checks++; if (bram_rddata_a !== D1) begin errors++; $display("FAIL b2b_rddata_hold got %h want %h", bram_rddata_a, D1); end
        checks++; if (ctrl_reg[0 +: DW] !== D0 || ctrl_reg[2*DW +: DW] !== D2) begin errors++; $display("FAIL b2b_words got %h want %h_%h", ctrl_reg, D2, D0); end
    endtask

    task automatic test_raw();
        drive(1'b1, '1, 2, D3);
        tick();
        drive(1'b1, '0, 2, '0);
        tick();
        drive(1'b0, '0, 0, '0);
        tick();
        checks++; if (bram_rdvalid_a !== 1'b1) begin errors++; $display("FAIL raw_rdvalid got %b want 1", bram_rdvalid_a); end
        checks++; if (bram_rddata_a !== D3) begin errors++; $display("FAIL raw_rddata got %h want %h", bram_rddata_a, D3); end
    endtask

    task automatic test_status();
        // snapshot read first so both configurations hold current values
        drive(1'b1, '0, NC, '0);
        tick();
        drive(1'b0, '0, 0, '0);
        tick();
        checks++; if (bram_rddata_a !== S0) begin errors++; $display("FAIL stat_word0 got %h want %h", bram_rddata_a, S0); end
        drive(1'b1, '0, NC + 5, '0);
        tick();
        drive(1'b0, '0, 0, '0);
        tick();
        checks++; if (bram_rdvalid_a !== 1'b1) begin errors++; $display("FAIL stat_rdvalid got %b want 1", bram_rdvalid_a); end
        checks++; if (bram_rddata_a !== S5) begin errors++; $display("FAIL stat_word5 got %h want %h", bram_rddata_a, S5); end
        tick();
        checks++; if (bram_rdvalid_a !== 1'b0) begin errors++; $display("FAIL stat_rdvalid_late got %b want 0", bram_rdvalid_a); end
    endtask

    task automatic test_snapshot();
        logic [DW-1:0] exp1;
`ifdef BYPASS_STAT_SNAP_EN
        exp1 = S1;
`else
        exp1 = S1N;
`endif
        drive(1'b1, '0, NC, '0);
        tick();
        drive(1'b0, '0, 0, '0);
        tick();
        checks++; if (bram_rddata_a !== S0) begin errors++; $display("FAIL snap_word0 got %h want %h", bram_rddata_a, S0); end
        set_stat(1, S1N);
        repeat (3) tick();
        drive(1'b1, '0, NC + 1, '0);
        tick();
        drive(1'b0, '0, 0, '0);
        tick();
        checks++; if (bram_rddata_a !== exp1) begin errors++; $display("FAIL snap_word1 got %h want %h", bram_rddata_a, exp1); end
    endtask

    task automatic test_errors();
        drive(1'b1, '1, NC, D2);
        tick();
        drive(1'b0, '0, 0, '0);
        tick();
        checks++; if (acc_err_cnt !== 16'd1) begin errors++; $display("FAIL err_stat_write got %h want 0001", acc_err_cnt); end
        drive(1'b1, '0, NC + NS, '0);
        tick();
        drive(1'b0, '0, 0, '0);
        tick();
        checks++; if (bram_rdvalid_a !== 1'b1) begin errors++; $display("FAIL err_oor_rdvalid got %b want 1", bram_rdvalid_a); end
        checks++; if (bram_rddata_a !== '0) begin errors++; $display("FAIL err_oor_rddata got %h want 0", bram_rddata_a); end
        checks++; if (acc_err_cnt !== 16'd2) begin errors++; $display("FAIL err_oor_read got %h want 0002", acc_err_cnt); end
        drive(1'b1, '1, 15, D2);
        tick();
        drive(1'b0, '0, 0, '0);
        tick();
        checks++; if (acc_err_cnt !== 16'd3) begin errors++; $display("FAIL err_oor_write got %h want 0003", acc_err_cnt); end
        checks++; if (ctrl_wr_pulse !== 4'b0000) begin errors++; $display("FAIL err_no_pulse got %b want 0000", ctrl_wr_pulse); end
    endtask

    task automatic test_saturate();
        drive(1'b1, '1, 12, D2);
        repeat (65531) tick();
        drive(1'b0, '0, 0, '0);
        tick();
        checks++; if (acc_err_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_near got %h want fffe", acc_err_cnt); end
        drive(1'b1, '1, 12, D2);
        repeat (10) tick();
        drive(1'b0, '0, 0, '0);
        repeat (2) tick();
        checks++; if (acc_err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", acc_err_cnt); end
        checks++; if (ctrl_reg[0 +: DW] !== D0) begin errors++; $display("FAIL sat_word0 got %h want %h", ctrl_reg[0 +: DW], D0); end
    endtask

    initial begin
        stat_reg = '0;
        set_stat(0, S0);
        set_stat(1, S1);
        set_stat(2, 64'h0000_0000_0000_1002);
        set_stat(3, 64'h0000_0000_0000_1003);
        set_stat(4, 64'h0000_0000_0000_1004);
        set_stat(5, S5);
        test_reset();
        test_byte_mask();
        test_back_to_back();
        test_raw();
        test_status();
        test_snapshot();
        test_errors();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
